dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-ported data memory between the ARM core's load/store path and
//  an external host port (loader/debug/DMA). Sits between core+port decode and dmem.
//  Grants at most one requester per cycle; round-robin fairness with optional bounded
//  host bursts; stalls the core while the host owns the memory.
// PARAMETERS
//  ADDR_W     32  address width, both requesters and memory
//  DATA_W     32  data width
//  BURST_MAX  4   max consecutive locked host grants while core waits (>=1)
// PORTS
//  clk        in   1       clock
//  reset      in   1       asynchronous, active-high reset
//  cpu_req    in   1       core memory access this cycle (MemtoReg|MemWrite)
//  cpu_we     in   1       core write strobe
//  cpu_addr   in   ADDR_W  core byte address
//  cpu_wdata  in   DATA_W  core write data
//  cpu_rdata  out  DATA_W  read data to core (valid when cpu_req & ~cpu_stall)
//  cpu_stall  out  1       core must hold PC and suppress RegWrite/flag update
//  ext_req    in   1       host access request
//  ext_we     in   1       host write strobe
//  ext_lock   in   1       host requests to keep grant next cycle (burst)
//  ext_addr   in   ADDR_W  host byte address
//  ext_wdata  in   DATA_W  host write data
//  ext_rdata  out  DATA_W  read data to host (valid when ext_ack)
//  ext_ack    out  1       host access performed this cycle
//  mem_we     out  1       dmem write enable
//  mem_addr   out  ADDR_W  dmem address
//  mem_wdata  out  DATA_W  dmem write data
//  mem_rdata  in   DATA_W  dmem combinational read data
// BEHAVIOUR
//  - Grant decided combinationally each cycle from requests + registered state;
//    access completes in the same cycle (async read, write at next posedge).
//  - State: last_owner (CPU/EXT), burst_cnt (0..BURST_MAX), locked flag.
//  - Only one requester -> granted. None -> no grant, mem_we=0, mem_addr=cpu_addr.
//  - Both, not locked -> requester that is not last_owner wins.
//  - Locked (prev cycle ext granted with ext_lock=1) and ext_req -> EXT wins while
//    burst_cnt < BURST_MAX; at burst_cnt==BURST_MAX and cpu_req, CPU forced win,
//    lock cleared. Lock with cpu_req=0 never counts toward BURST_MAX.
//  - ext_req drop ends lock immediately; ext_lock ignored when EXT not granted.
//  - burst_cnt: +1 per EXT grant while cpu_req=1, saturating; cleared on CPU grant
//    or lock end. last_owner updates only on a grant.
//  - cpu_stall = cpu_req & ~cpu_gnt; ext_ack = ext_gnt. Both rdata = mem_rdata.
//  - mem_we = granted requester's we; never asserted without a grant.
//  - Reset (async): last_owner=EXT (core wins first contention), burst_cnt=0,
//    locked=0; while reset high cpu_stall=0, ext_ack=0, mem_we=0.
//  - Reset mid-burst drops lock; no write is issued in the reset cycle.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds output stall_cnt [15:0], incremented each cycle
//   cpu_stall=1, saturates at 16'hFFFF, cleared by reset; plus output ext_cnt [15:0]
//   counting ext_ack cycles, same rules.
//  Not defined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  cpu_req only, cpu_we=1, addr 0x10, wdata 0xCAFE -> mem_we=1, cpu_stall=0; read back 0xCAFE
//  ext_req only, read addr 0x10 -> ext_ack=1 same cycle, ext_rdata=0xCAFE
//  both req 4 cycles, no lock, after reset -> grants CPU,EXT,CPU,EXT; stall on cycles 2,4
//  both req, ext_lock=1, BURST_MAX=4 -> EXT after CPU: 4 EXT acks then forced CPU grant
//  reset asserted mid-burst with ext_we=1 -> mem_we=0 immediately; next contention CPU wins
//  STATS_EN: 3 stall cycles then reset -> stall_cnt 3 then 0; 70000 stalls -> 0xFFFF

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the three buses around the data-memory arbiter: the core
//   load/store port, the host (loader/debug/DMA) port and the dmem port.
//   modport slave  : arbiter view (takes requests, drives grants and dmem).
//   modport master : environment view (core, host and dmem model).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // core side
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;
   // host side
   logic              ext_req;
   logic              ext_we;
   logic              ext_lock;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic [DATA_W-1:0] ext_rdata;
   logic              ext_ack;
   // dmem side
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
      output ext_rdata, ext_ack,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
      input  ext_rdata, ext_ack,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-ported data memory between the core load/store path and
//   the host port. At most one grant per cycle, decided combinationally; the
//   access completes in the same cycle (async read, write at next posedge).
//   Round-robin on contention; the host may lock the memory for a burst of up
//   to BURST_MAX consecutive grants while the core waits, then the core is
//   forced in.
//
//   Ports
//     clk, reset  clock, asynchronous active-high reset
//     bus         dmem_arbiter_if.slave (core, host and dmem buses)
//     stall_cnt   (DMEM_ARB_STATS_EN) saturating count of cpu_stall cycles
//     ext_cnt     (DMEM_ARB_STATS_EN) saturating count of ext_ack cycles
//
//   Build option: define DMEM_ARB_STATS_EN to add the two stats counters.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
`ifdef DMEM_ARB_STATS_EN
   output logic [15:0] stall_cnt,
   output logic [15:0] ext_cnt,
`endif
   dmem_arbiter_if.slave bus
);

   localparam int            CW      = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);
   localparam logic [CW-1:0] BMAX    = CW'(BURST_MAX);
   localparam logic [0:0]    OWN_CPU = 1'b0;
   localparam logic [0:0]    OWN_EXT = 1'b1;

   logic [0:0]    last_owner_q, last_owner_d;
   logic [CW-1:0] burst_cnt_q,  burst_cnt_d;
   logic          locked_q,     locked_d;
   logic          cpu_gnt, ext_gnt;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;

   // Grant: nothing while reset is high, so no write can slip into that cycle.
   always_comb begin
      cpu_gnt = 1'b0;
      ext_gnt = 1'b0;
      if (!reset) begin
         if (bus.cpu_req && bus.ext_req) begin
            if (locked_q) begin
               if (burst_cnt_q < BMAX) ext_gnt = 1'b1;
               else                    cpu_gnt = 1'b1;
            end else if (last_owner_q == OWN_CPU) begin
               ext_gnt = 1'b1;
            end else begin
               cpu_gnt = 1'b1;
            end
         end else begin
            // A held lock with ext_req dropped lands here and simply lapses.
            cpu_gnt = bus.cpu_req;
            ext_gnt = bus.ext_req;
         end
      end
   end

   // Lock only survives a cycle in which the host was actually granted. The
   // burst count only advances while the core is waiting, and is zero
   // whenever no lock is carried into the next cycle.
   always_comb begin
      locked_d     = ext_gnt & bus.ext_lock;
      burst_cnt_d  = '0;
      if (locked_d) begin
         if (bus.cpu_req && (burst_cnt_q != BMAX)) burst_cnt_d = burst_cnt_q + 1'b1;
         else                                      burst_cnt_d = burst_cnt_q;
      end
      last_owner_d = last_owner_q;
      if (cpu_gnt)      last_owner_d = OWN_CPU;
      else if (ext_gnt) last_owner_d = OWN_EXT;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_owner_q <= OWN_EXT;   // core wins the first contention
         burst_cnt_q  <= '0;
         locked_q     <= 1'b0;
      end else begin
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         locked_q     <= locked_d;
      end
   end

   // Idle memory still presents the core address.
   assign addr_sel      = ext_gnt ? bus.ext_addr  : bus.cpu_addr;
   assign wdata_sel     = ext_gnt ? bus.ext_wdata : bus.cpu_wdata;
   assign bus.mem_addr  = addr_sel;
   assign bus.mem_wdata = wdata_sel;
   assign bus.mem_we    = (cpu_gnt & bus.cpu_we) | (ext_gnt & bus.ext_we);
   assign bus.cpu_rdata = bus.mem_rdata;
   assign bus.ext_rdata = bus.mem_rdata;
   assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt & ~reset;
   assign bus.ext_ack   = ext_gnt;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stall_cnt_q, ext_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         ext_cnt_q   <= '0;
      end else begin
         if (bus.cpu_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
         if (ext_gnt && (ext_cnt_q != 16'hFFFF))         ext_cnt_q   <= ext_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign ext_cnt   = ext_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Drives random and directed traffic into dmem_arbiter, models dmem as a
//   16-word array (index = addr[5:2]) and checks every cycle against a
//   behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
   localparam int BURST_MAX = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stall_cnt, ext_cnt;
`endif

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(BURST_MAX)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef DMEM_ARB_STATS_EN
      .stall_cnt (stall_cnt),
      .ext_cnt   (ext_cnt),
`endif
      .bus       (bus)
   );

   // dmem: async read, write at posedge, preloaded on the first edge
   logic [31:0] dmem [16];
   bit          mem_init_done = 1'b0;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 16; i++) dmem[i] <= 32'h1000_0000 + i * 32'h0101_0101;
         mem_init_done <= 1'b1;
      end else if (bus.mem_we) begin
         dmem[bus.mem_addr[5:2]] <= bus.mem_wdata;
      end
   end
   assign bus.mem_rdata = dmem[bus.mem_addr[5:2]];

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_init = 1'b0;
   bit          m_prev_ext;    // who had the memory most recently
   bit          m_lock;        // host holds a burst lock into this cycle
   int          m_run;         // host grants in current burst while core waited
   logic [31:0] mm [16];
   int          m_stall, m_ext;

   always @(negedge clk) begin
      bit cr, er, cg, eg, we;
      logic [31:0] addr, wdata;
      if (!m_init) begin
         for (int i = 0; i < 16; i++) mm[i] = 32'h1000_0000 + i * 32'h0101_0101;
         m_init = 1'b1;
      end
      cr = bus.cpu_req;
      er = bus.ext_req;
      cg = 1'b0;
      eg = 1'b0;
      if (reset) begin
         m_prev_ext = 1'b1;
         m_lock     = 1'b0;
         m_run      = 0;
         m_stall    = 0;
         m_ext      = 0;
      end else if (cr && er) begin
         if (m_lock) begin
            if (m_run < BURST_MAX) eg = 1'b1;
            else                   cg = 1'b1;
         end else if (m_prev_ext) cg = 1'b1;
         else                     eg = 1'b1;
      end else begin
         cg = cr;
         eg = er;
      end
      we    = (cg && bus.cpu_we) || (eg && bus.ext_we);
      addr  = eg ? bus.ext_addr  : bus.cpu_addr;
      wdata = eg ? bus.ext_wdata : bus.cpu_wdata;

      chk("cpu_stall", 32'(bus.cpu_stall), 32'(cr && !cg && !reset));
      chk("ext_ack",   32'(bus.ext_ack),   32'(eg));
      chk("mem_we",    32'(bus.mem_we),    32'(we));
      chk("mem_addr",  bus.mem_addr,       addr);
      if (we)                chk("mem_wdata", bus.mem_wdata, wdata);
      if (cg && !bus.cpu_we) chk("cpu_rdata", bus.cpu_rdata, mm[addr[5:2]]);
      if (eg && !bus.ext_we) chk("ext_rdata", bus.ext_rdata, mm[addr[5:2]]);
`ifdef DMEM_ARB_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("ext_cnt",   32'(ext_cnt),   32'(m_ext));
`endif
      if (!reset) begin
         if (cg)      m_prev_ext = 1'b0;
         else if (eg) m_prev_ext = 1'b1;
         m_lock = eg && bus.ext_lock;
         if (!m_lock)                       m_run = 0;
         else if (cr && m_run < BURST_MAX)  m_run = m_run + 1;
         if (cr && !cg && m_stall < 65535) m_stall++;
         if (eg && m_ext < 65535)          m_ext++;
         if (we) mm[addr[5:2]] = wdata;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic look();
      @(negedge clk); #1;
   endtask

   task automatic drv(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                      input bit er, input bit ew, input bit el, input logic [31:0] ea,
                      input logic [31:0] ed);
      bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
      bus.ext_req = er; bus.ext_we = ew; bus.ext_lock = el; bus.ext_addr = ea;
      bus.ext_wdata = ed;
   endtask

   logic [3:0] pat;

   initial begin
      reset = 1'b1;
      drv(1, 1, 32'h20, 32'h1111, 1, 1, 1, 32'h24, 32'h2222);

      // requests and write strobes held during reset must be suppressed
      look();
      chk("rst_stall",  32'(bus.cpu_stall), 32'd0);
      chk("rst_ack",    32'(bus.ext_ack),   32'd0);
      chk("rst_mem_we", 32'(bus.mem_we),    32'd0);

      cyc(); reset = 1'b0; drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // core write then read-back
      cyc(); drv(1, 1, 32'h10, 32'hCAFE, 0, 0, 0, 0, 0);
      look();
      chk("wr_mem_we", 32'(bus.mem_we),    32'd1);
      chk("wr_stall",  32'(bus.cpu_stall), 32'd0);
      cyc(); drv(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      look();
      chk("cpu_rd", bus.cpu_rdata, 32'hCAFE);

      // host read, acked the same cycle
      cyc(); drv(0, 0, 0, 0, 1, 0, 0, 32'h10, 0);
      look();
      chk("ext_ack1", 32'(bus.ext_ack), 32'd1);
      chk("ext_rd",   bus.ext_rdata,    32'hCAFE);

      // after reset, unlocked contention alternates CPU,EXT,CPU,EXT
      cyc(); reset = 1'b1; drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(); reset = 1'b0;
      pat = 4'b1010;  // bit i = ext wins cycle i
      for (int i = 0; i < 4; i++) begin
         if (i != 0) cyc();
         drv(1, 0, 32'h4, 0, 1, 0, 0, 32'h8, 0);
         look();
         chk("rr_ack",   32'(bus.ext_ack),   32'(pat[i]));
         chk("rr_stall", 32'(bus.cpu_stall), 32'(pat[i]));
      end

      // locked burst: CPU first (EXT owned last), then 4 EXT, forced CPU, EXT
      for (int i = 0; i < 7; i++) begin
         cyc(); drv(1, 0, 32'h4, 0, 1, 0, 1, 32'h8, 0);
         look();
         chk("burst_ack", 32'(bus.ext_ack), 32'((i >= 1 && i <= 4) || i == 6));
      end

      // reset mid-burst with a host write pending: no write, lock dropped
      cyc(); reset = 1'b1; drv(1, 0, 32'h4, 0, 1, 1, 1, 32'h8, 32'hDEAD);
      look();
      chk("midrst_we",  32'(bus.mem_we),  32'd0);
      chk("midrst_ack", 32'(bus.ext_ack), 32'd0);
      cyc(); reset = 1'b0; drv(1, 0, 32'h4, 0, 1, 0, 0, 32'h8, 0);
      look();
      chk("postrst_stall", 32'(bus.cpu_stall), 32'd0);
      chk("postrst_ack",   32'(bus.ext_ack),   32'd0);

      // random traffic, model checks every cycle
      for (int i = 0; i < 4000; i++) begin
         cyc();
         reset = ($urandom_range(0, 99) == 0);
         drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom & 32'hFFFF_FFFC, $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) != 0, $urandom & 32'hFFFF_FFFC, $urandom);
      end

`ifdef DMEM_ARB_STATS_EN
      // 3 stall cycles: CPU wins, then 3 locked host grants
      cyc(); reset = 1'b1; drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(); reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) cyc();
         drv(1, 0, 32'h4, 0, 1, 0, 1, 32'h8, 0);
      end
      cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      look();
      chk("stall_cnt3", 32'(stall_cnt), 32'd3);
      cyc(); reset = 1'b1;
      look();
      chk("stall_cnt0", 32'(stall_cnt), 32'd0);
      cyc(); reset = 1'b0;

      // long locked contention: stalls 4 of every 5 cycles, saturates
      drv(1, 0, 32'h4, 0, 1, 0, 1, 32'h8, 0);
      for (int i = 0; i < 82000; i++) cyc();
      look();
      chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
`endif

      cyc(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      look();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
